ps2_tx: RTL
===========

Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse over the shared ps2d/ps2c lines.
- Sits beside the existing PS/2 receive path in the mouse unit; the receiver gets the lines only while tx_idle=1.
- Implements request-to-send, device-clocked bit shifting, odd parity, stop bit and a watchdog.

Parameters:
- RTS_CYCLES, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz).
- FILT_LEN, 8, consecutive equal ps2c samples needed to change the filtered clock level.
- TIMEOUT_CYCLES, 1000000, max clk cycles without a filtered ps2c falling edge in START/DATA/STOP/ACK before abort (20 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_ps2  in  1  write strobe; accepted only in IDLE
- din  in  8  byte to send, captured with wr_ps2
- ps2d  inout  1  PS/2 data; only driven low (0) or released (Z)
- ps2c  inout  1  PS/2 clock; only driven low or released
- tx_idle  out  1  1 in IDLE
- tx_done_tick  out  1  one-cycle pulse, frame completed
- tx_timeout_tick  out  1  one-cycle pulse, frame aborted by watchdog

Behaviour:
- Reset (synchronous, active-high), on the next clk edge: state=IDLE, both lines released, tx_idle=1, ticks=0, filter level=1, counters=0. Reset mid-frame aborts with no tick.
- Clock filter: shift register of ps2c samples. All-ones sets f_val=1; all-zeros sets f_val=0; otherwise hold. fall_edge = f_val 1->0 (one cycle). Filtered data (ps2d synchronised through 2 flops) is used only for ACK.
- Tristate controls are registered. Line = 0 when drive enabled, else Z. No glitch on state entry.
- IDLE: lines released.
  - wr_ps2=1 loads shift reg {par, din}, par = ~^din (odd parity), sets cnt=0, goes to RTS.
  - wr_ps2 outside IDLE is ignored.
- RTS: drive ps2c low, ps2d released. After RTS_CYCLES cycles go to START.
- START: release ps2c, drive ps2d low (start bit). On fall_edge: go to DATA, n=8.
- DATA: ps2d driven low iff shift_reg[0]=0, else released.
  - On fall_edge: shift right.
  - n=0 → STOP, else n--. Order: d0..d7, then parity (9 bits).
- STOP: release ps2d (stop=1). On fall_edge → IDLE with tx_done_tick (or → ACK if option enabled).
- Watchdog: counter clears on every fall_edge and on entering START. If it reaches TIMEOUT_CYCLES in START/DATA/STOP/ACK: release both lines, pulse tx_timeout_tick, go to IDLE.
- tx_idle is combinational from state.
- tx_done_tick and tx_timeout_tick are never both asserted.
- Latency with ideal device: RTS_CYCLES + 11 device clock falling edges.

Optional Feature:
- Macro: PS2_TX_ACK_CHK_EN.
- Defined:
  - STOP goes to ACK state. On the next fall_edge, sample filtered ps2d: 0 = acknowledged, 1 = error.
  - Adds output tx_ack_err (1 bit): valid with the tx_done_tick pulse, otherwise 0.
  - The watchdog covers ACK.
- Undefined: no ACK state, no tx_ack_err port; done at STOP edge.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, RTS, START, DATA, STOP, ACK)
  - command constants CMD_RESET=8'hFF, CMD_EN_REPORT=8'hF4
  - response constant RSP_ACK=8'hFA
- Sub-module ps2_clk_filter (clk, reset, ps2c → f_val, fall_edge), parameterised by FILT_LEN and reusable by the receiver.

Test Plan:
- din=0xF4, device model clocking at 12.5 kHz → ps2c low exactly 5000 cycles; start 0; data bits 0,0,1,0,1,1,1,1; parity 0; stop released; tx_done_tick once; tx_idle=1 after.
- din=0x00 then 0xFF back-to-back → parity bits 1 and 1; second wr_ps2 pulsed mid-frame ignored; exactly two tx_done_tick.
- ps2c glitch of 3 cycles low during DATA → no fall_edge, no extra bit shift; frame still correct.
- Device never clocks after RTS → tx_timeout_tick after 1000000 cycles, lines Z, no tx_done_tick.
- reset=1 during DATA bit 4 → next cycle both lines Z, IDLE, no ticks; new 0xF4 write then completes normally.
- PS2_TX_ACK_CHK_EN: device holds data low on ack edge → tx_ack_err=0; device leaves it high → tx_ack_err=1 with tx_done_tick.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host-side transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK
  } ps2_state_t;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock line: the filtered level only changes after FILT_LEN equal samples.
module ps2_clk_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic f_val,
  output logic fall_edge
);

  logic [FILT_LEN-1:0] r_shift;
  logic                r_fval;
  logic                w_fval_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '1;
      r_fval  <= 1'b1;
    end else begin
      r_shift <= {ps2c, r_shift[FILT_LEN-1:1]};
      r_fval  <= w_fval_next;
    end
  end

  always_comb begin
    w_fval_next = r_fval;
    if (&r_shift)
      w_fval_next = 1'b1;
    else if (~|r_shift)
      w_fval_next = 1'b0;
  end

  assign f_val     = r_fval;
  // High for the single cycle in which the filtered level commits to 0.
  assign fall_edge = r_fval & ~w_fval_next;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter with request-to-send and watchdog.
// Define PS2_TX_ACK_CHK_EN to add the device acknowledge check and tx_ack_err output.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 5000,
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_timeout_tick
`ifdef PS2_TX_ACK_CHK_EN
  ,
  output logic       tx_ack_err
`endif
);

  localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_state_t r_state, w_state_next;
  logic [8:0]    r_shift, w_shift_next;
  logic [3:0]    r_n, w_n_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_c_drv, w_c_drv_next;
  logic          r_d_drv, w_d_drv_next;
  logic          r_done, w_done_next;
  logic          r_tmo, w_tmo_next;
  logic          w_fall;
  logic          w_fval_unused;
  logic          w_tmo_hit;
  logic          w_watched;

  ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .f_val     (w_fval_unused),
    .fall_edge (w_fall)
  );

`ifdef PS2_TX_ACK_CHK_EN
  logic [1:0] r_d_sync;
  logic       r_ack_err, w_ack_err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_sync  <= 2'b11;
      r_ack_err <= 1'b0;
    end else begin
      r_d_sync  <= {r_d_sync[0], ps2d};
      r_ack_err <= w_ack_err_next;
    end
  end

  assign tx_ack_err = r_ack_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_c_drv <= 1'b0;
      r_d_drv <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_n     <= w_n_next;
      r_cnt   <= w_cnt_next;
      r_c_drv <= w_c_drv_next;
      r_d_drv <= w_d_drv_next;
      r_done  <= w_done_next;
      r_tmo   <= w_tmo_next;
    end
  end

  assign w_watched = (r_state == START) || (r_state == DATA) ||
                     (r_state == STOP)  || (r_state == ACK);
  assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !w_fall;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_n_next     = r_n;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_tmo_next   = 1'b0;
`ifdef PS2_TX_ACK_CHK_EN
    w_ack_err_next = 1'b0;
`endif
    case (r_state)
      IDLE: if (wr_ps2) begin
        w_shift_next = {odd_parity(din), din};
        w_n_next     = '0;
        w_cnt_next   = '0;
        w_state_next = RTS;
      end
      RTS: begin
        if (r_cnt == CW'(RTS_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = START;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      START: if (w_fall) begin
        w_n_next     = 4'd8;
        w_state_next = DATA;
      end
      DATA: if (w_fall) begin
        w_shift_next = {1'b1, r_shift[8:1]};
        if (r_n == 4'd0)
          w_state_next = STOP;
        else
          w_n_next = r_n - 4'd1;
      end
      STOP: if (w_fall) begin
`ifdef PS2_TX_ACK_CHK_EN
        w_state_next = ACK;
`else
        w_state_next = IDLE;
        w_done_next  = 1'b1;
`endif
      end
      ACK: if (w_fall) begin
        w_state_next = IDLE;
        w_done_next  = 1'b1;
`ifdef PS2_TX_ACK_CHK_EN
        w_ack_err_next = r_d_sync[1];
`endif
      end
      default: w_state_next = IDLE;
    endcase

    // Watchdog shares the counter with RTS; an edge always wins over expiry.
    if (w_watched) begin
      if (w_fall) begin
        w_cnt_next = '0;
      end else if (w_tmo_hit) begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
        w_tmo_next   = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // Drive enables follow the next state so the lines change on the same edge as the state.
  always_comb begin
    tx_idle      = (r_state == IDLE);
    w_c_drv_next = (w_state_next == RTS);
    w_d_drv_next = (w_state_next == START) ||
                   ((w_state_next == DATA) && !w_shift_next[0]);
  end

  assign ps2c            = r_c_drv ? 1'b0 : 1'bz;
  assign ps2d            = r_d_drv ? 1'b0 : 1'bz;
  assign tx_done_tick    = r_done;
  assign tx_timeout_tick = r_tmo;

endmodule
